// File: rtl/line_valid_ctrl_if.sv
// Handshake/bus bundle for the cache-line valid-bit controller.
// The tag-array side (master) drives lookups, set/clear and flush requests.
interface line_valid_ctrl_if #(
   parameter int IDX_W = 5
);
   localparam int ENTRIES = 1 << IDX_W;

   logic [IDX_W-1:0]   rd_idx;
   logic [ENTRIES-1:0] onehot_out;
   logic               rd_valid;
   logic               set_en;
   logic [IDX_W-1:0]   set_idx;
   logic               clr_en;
   logic [IDX_W-1:0]   clr_idx;
   logic               flush_req;
   logic               flush_busy;
   logic               flush_done;
   logic [ENTRIES-1:0] valid_vec;
   logic [IDX_W:0]     valid_count;

   modport master (
      output rd_idx, set_en, set_idx, clr_en, clr_idx, flush_req,
      input  onehot_out, rd_valid, flush_busy, flush_done, valid_vec, valid_count
   );

   modport slave (
      input  rd_idx, set_en, set_idx, clr_en, clr_idx, flush_req,
      output onehot_out, rd_valid, flush_busy, flush_done, valid_vec, valid_count
   );
endinterface

// File: rtl/line_valid_ctrl.sv
// Cache-line valid-bit controller: registered index decode and valid lookup,
// per-entry set/clear, incremental valid count and a sequential flush sweeper.
//
// state   | meaning
// S_IDLE  | set/clear accepted; flush_req starts a sweep at entry 0
// S_SWEEP | clears one entry per cycle, flush_busy=1, set/clear dropped
// S_DONE  | one-cycle flush_done pulse, set/clear dropped
module line_valid_ctrl #(
   parameter int IDX_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   line_valid_ctrl_if.slave   bus
);
   localparam int ENTRIES = 1 << IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [ENTRIES-1:0] vec_q, vec_d;
   logic [IDX_W:0]     cnt_q, cnt_d;
   logic [ENTRIES-1:0] onehot_q;
   logic               rdv_q;
   logic               set_hit, clr_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         vec_q    <= '0;
         cnt_q    <= '0;
         onehot_q <= '0;
         rdv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         vec_q    <= vec_d;
         cnt_q    <= cnt_d;
         onehot_q <= {{(ENTRIES-1){1'b0}}, 1'b1} << bus.rd_idx;
         rdv_q    <= vec_q[bus.rd_idx];
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      set_hit = 1'b0;
      clr_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Only real state changes move the count; a same-index clear overrides the set.
            set_hit = bus.set_en && !vec_q[bus.set_idx] &&
                      !(bus.clr_en && (bus.clr_idx == bus.set_idx));
            clr_hit = bus.clr_en && vec_q[bus.clr_idx];
            if (bus.set_en) vec_d[bus.set_idx] = 1'b1;
            if (bus.clr_en) vec_d[bus.clr_idx] = 1'b0;
            cnt_d = cnt_q + (IDX_W+1)'(set_hit) - (IDX_W+1)'(clr_hit);
            ptr_d = '0;
            if (bus.flush_req) state_d = S_SWEEP;
         end
         S_SWEEP: begin
            vec_d[ptr_q] = 1'b0;
            if (vec_q[ptr_q]) cnt_d = cnt_q - (IDX_W+1)'(1);
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == IDX_W'(ENTRIES-1)) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.onehot_out  = onehot_q;
   assign bus.rd_valid    = rdv_q;
   assign bus.valid_vec   = vec_q;
   assign bus.valid_count = cnt_q;
   assign bus.flush_busy  = (state_q == S_SWEEP);
   assign bus.flush_done  = (state_q == S_DONE);
endmodule
